// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: steps fetch/decode/execute/mem/writeback and
// drives the PC, IR, register-file, ALU, status and data-memory strobes.
module ctrl_seq #(
   parameter int OP_W     = 4,
   parameter int AM_W     = 4,
   parameter int STAT_W   = 4,
   parameter int ALU_OP_W = 2,
   parameter int SKIP_MEM = 0,
   parameter int WAIT_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_f,
   input  logic [OP_W-1:0]     opcode,
   input  logic [AM_W-1:0]     mm,
   input  logic [STAT_W-1:0]   stat,
   input  logic                mem_ack,
   output logic                pc_write,
   output logic                pc_sel,
   output logic                pc_rel,
   output logic                ir_load,
   output logic                rf_we,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                wb_sel,
   output logic                stat_en,
   output logic                mem_req,
   output logic                mem_we,
   output logic                halted,
   output logic                bus_err,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_START0    = 3'd0,
      S_START1    = 3'd1,
      S_FETCH     = 3'd2,
      S_DECODE    = 3'd3,
      S_EXECUTE   = 3'd4,
      S_MEM       = 3'd5,
      S_WRITEBACK = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   state_t           cur, nxt;
   logic [CNT_W-1:0] wait_cnt;

   logic is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt;
   logic is_mem, is_imm, cond_hit, taken, timeout;
   logic [ALU_OP_W-1:0] alu_hold;

   assign is_lod = (opcode == OP_W'(1));
   assign is_str = (opcode == OP_W'(2));
   assign is_swp = (opcode == OP_W'(3));
   assign is_bra = (opcode == OP_W'(4));
   assign is_brr = (opcode == OP_W'(5));
   assign is_bne = (opcode == OP_W'(6));
   assign is_bnr = (opcode == OP_W'(7));
   assign is_alu = (opcode == OP_W'(8));
   assign is_hlt = (opcode == OP_W'(15));
   assign is_mem = is_lod | is_str;
   assign is_imm = (mm == AM_W'(8));

   assign cond_hit = |(stat & mm[STAT_W-1:0]);
   assign taken    = ((is_bra | is_brr) & cond_hit) | ((is_bne | is_bnr) & ~cond_hit);

   // Memory handshake: mem_req stays high for the whole MEM stay of a LOD/STR;
   // the transfer completes in the cycle mem_ack is seen high (no ready-side
   // backpressure), and mem_ack is ignored in every other state.
   // The WAIT_MAX-th ackless cycle is the timeout cycle; an ack in it still wins.
   assign timeout = (WAIT_MAX > 0) && !mem_ack && (wait_cnt == CNT_W'(WAIT_MAX - 1));

   always_comb begin
      alu_hold = '0;
      if (is_alu)
         alu_hold = is_imm ? ALU_OP_W'(1) : '0;
      else if (is_mem)
         alu_hold = ALU_OP_W'(2);
      else if (is_swp)
         alu_hold = ALU_OP_W'(3);
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         cur      <= S_START0;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         cur <= nxt;
         if (cur != S_MEM && nxt == S_MEM)
            wait_cnt <= '0;
         else if (cur == S_MEM && !mem_ack)
            wait_cnt <= wait_cnt + 1'b1;
         if (cur == S_MEM && is_mem && timeout)
            bus_err <= 1'b1;
      end
   end

   always_comb begin
      nxt = cur;
      case (cur)
         S_START0:  nxt = S_START1;
         S_START1:  nxt = S_FETCH;
         S_FETCH:   nxt = S_DECODE;
         S_DECODE:  nxt = is_hlt ? S_HALT : S_EXECUTE;
         S_EXECUTE: begin
            if (SKIP_MEM == 0 || is_mem)
               nxt = S_MEM;
            else if (is_alu || is_swp)
               nxt = S_WRITEBACK;
            else
               nxt = S_FETCH;
         end
         S_MEM: begin
            if (!is_mem)
               nxt = S_WRITEBACK;
            else if (mem_ack)
               nxt = (SKIP_MEM != 0 && is_str) ? S_FETCH : S_WRITEBACK;
            else if (timeout)
               nxt = S_HALT;
         end
         S_WRITEBACK: nxt = S_FETCH;
         S_HALT:      nxt = S_HALT;
         default:     nxt = S_START0;
      endcase
   end

   always_comb begin
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      pc_rel   = 1'b0;
      ir_load  = 1'b0;
      rf_we    = 1'b0;
      alu_op   = '0;
      wb_sel   = 1'b0;
      stat_en  = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      case (cur)
         S_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_op  = alu_hold;
            stat_en = is_alu;
            if (taken) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               pc_rel   = is_brr | is_bnr;
            end
         end
         S_MEM: begin
            alu_op  = alu_hold;
            mem_req = is_mem;
            mem_we  = is_str;
         end
         S_WRITEBACK: begin
            alu_op = alu_hold;
            rf_we  = is_alu | is_lod | is_swp;
            wb_sel = is_lod;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign state = cur;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: dut0 runs SKIP_MEM=0/WAIT_MAX=4, dut1 runs SKIP_MEM=1/WAIT_MAX=8.
// An instruction-level model expands each instruction into its expected cycle trace.
module tb_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst_f   [2];
   logic [3:0] opcode  [2];
   logic [3:0] mm      [2];
   logic [3:0] stat    [2];
   logic       mem_ack [2];

   logic       pc_write[2], pc_sel[2], pc_rel[2], ir_load[2], rf_we[2];
   logic [1:0] alu_op  [2];
   logic       wb_sel[2], stat_en[2], mem_req[2], mem_we[2], halted[2], bus_err[2];
   logic [2:0] st      [2];
   logic [15:0] out_vec[2];

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   logic [12:0] drv_q[$];
   int   skip_p[2] = '{0, 1};
   int   wmax_p[2] = '{4, 8};
   logic berr_m[2];

   typedef struct {
      logic [3:0] op;
      logic [3:0] mm;
      logic [3:0] stat;
      int         w;
      int         len;
      logic       psel;
      logic       rfwe;
      logic       memwe;
   } vec_t;
   vec_t tbl[15];

   always #5 clk = ~clk;

   ctrl_seq #(.SKIP_MEM(0), .WAIT_MAX(4)) dut0 (
      .clk(clk), .rst_f(rst_f[0]), .opcode(opcode[0]), .mm(mm[0]), .stat(stat[0]),
      .mem_ack(mem_ack[0]), .pc_write(pc_write[0]), .pc_sel(pc_sel[0]), .pc_rel(pc_rel[0]),
      .ir_load(ir_load[0]), .rf_we(rf_we[0]), .alu_op(alu_op[0]), .wb_sel(wb_sel[0]),
      .stat_en(stat_en[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]), .halted(halted[0]),
      .bus_err(bus_err[0]), .state(st[0]));

   ctrl_seq #(.SKIP_MEM(1), .WAIT_MAX(8)) dut1 (
      .clk(clk), .rst_f(rst_f[1]), .opcode(opcode[1]), .mm(mm[1]), .stat(stat[1]),
      .mem_ack(mem_ack[1]), .pc_write(pc_write[1]), .pc_sel(pc_sel[1]), .pc_rel(pc_rel[1]),
      .ir_load(ir_load[1]), .rf_we(rf_we[1]), .alu_op(alu_op[1]), .wb_sel(wb_sel[1]),
      .stat_en(stat_en[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]), .halted(halted[1]),
      .bus_err(bus_err[1]), .state(st[1]));

   for (genvar g = 0; g < 2; g++) begin : g_pack
      assign out_vec[g] = {st[g], pc_write[g], pc_sel[g], pc_rel[g], ir_load[g], rf_we[g],
                           alu_op[g], wb_sel[g], stat_en[g], mem_req[g], mem_we[g],
                           halted[g], bus_err[g]};
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pk(input logic [2:0] s, input logic pw, ps, pr, il, rw,
                                      input logic [1:0] ao, input logic ws, se, mr, mw, h, be);
      return {s, pw, ps, pr, il, rw, ao, ws, se, mr, mw, h, be};
   endfunction

   task automatic push(input logic [15:0] e, input logic [3:0] op, m, s, input logic a);
      exp_q.push_back(e);
      drv_q.push_back({op, m, s, a});
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected trace of one instruction, starting at its FETCH cycle.
   // w = MEM cycles before mem_ack for LOD/STR; nh = HALT cycles to check.
   task automatic build_instr(input int d, input logic [3:0] op, m, s, input int w, input int nh);
      logic       is_mem, is_alu, hit, taken, be, timed;
      logic [1:0] hold;
      int         sk, wm, n;
      sk     = skip_p[d];
      wm     = wmax_p[d];
      be     = berr_m[d];
      is_mem = (op == 4'd1) || (op == 4'd2);
      is_alu = (op == 4'd8);
      hit    = (s & m) != 4'd0;
      taken  = ((op == 4'd4 || op == 4'd5) && hit) || ((op == 4'd6 || op == 4'd7) && !hit);
      hold   = is_alu ? ((m == 4'd8) ? 2'd1 : 2'd0) : is_mem ? 2'd2 : (op == 4'd3) ? 2'd3 : 2'd0;
      push(pk(3'd2, 1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, be), op, m, s, rnd_bit());
      push(pk(3'd3, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, be), op, m, s, rnd_bit());
      if (op == 4'd15) begin
         for (int k = 0; k < nh; k++)
            push(pk(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, be), op, m, s, rnd_bit());
         return;
      end
      push(pk(3'd4, taken, taken, taken && (op == 4'd5 || op == 4'd7), 0, 0, hold, 0, is_alu,
              0, 0, 0, be), op, m, s, rnd_bit());
      if (sk == 0 || is_mem) begin
         if (is_mem) begin
            timed = (wm > 0) && (w >= wm);
            n     = timed ? wm : w + 1;
            for (int k = 0; k < n; k++)
               push(pk(3'd5, 0, 0, 0, 0, 0, hold, 0, 0, 1, op == 4'd2, 0, be), op, m, s, k == w);
            if (timed) begin
               berr_m[d] = 1'b1;
               for (int k = 0; k < nh; k++)
                  push(pk(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 1), op, m, s, rnd_bit());
               return;
            end
         end else begin
            push(pk(3'd5, 0, 0, 0, 0, 0, hold, 0, 0, 0, 0, 0, be), op, m, s, rnd_bit());
         end
         if (sk != 0 && op == 4'd2)
            return;
      end else if (!(op == 4'd8 || op == 4'd3)) begin
         return;
      end
      push(pk(3'd6, 0, 0, 0, 0, (op == 4'd8 || op == 4'd1 || op == 4'd3), hold, op == 4'd1,
              0, 0, 0, 0, be), op, m, s, rnd_bit());
   endtask

   task automatic run_q(input int d, input int n);
      logic [15:0] e;
      logic [12:0] dv;
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         e  = exp_q.pop_front();
         dv = drv_q.pop_front();
         opcode[d]  = dv[12:9];
         mm[d]      = dv[8:5];
         stat[d]    = dv[4:1];
         mem_ack[d] = dv[0];
         #1;
         check($sformatf("dut%0d_cycle", d), out_vec[d], e);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic start_dut(input int d);
      berr_m[d] = 1'b0;
      rst_f[d]  = 1'b1;
      push(pk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0), 4'd0, 4'd0, 4'd0, rnd_bit());
      push(pk(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0), 4'd0, 4'd0, 4'd0, rnd_bit());
   endtask

   // Assert reset between clock edges and expect every output to clear at once.
   task automatic do_reset(input int d);
      #2;
      rst_f[d] = 1'b0;
      #1;
      check($sformatf("dut%0d_async_reset", d), out_vec[d], 16'h0000);
      berr_m[d] = 1'b0;
      exp_q.delete();
      drv_q.delete();
      @(negedge clk);
   endtask

   task automatic random_instrs(input int d, input int cnt);
      logic [3:0] op, m, s;
      for (int i = 0; i < cnt; i++) begin
         op = 4'($urandom_range(0, 14));
         m  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         s  = 4'($urandom_range(0, 15));
         build_instr(d, op, m, s, $urandom_range(0, wmax_p[d] - 1), 0);
      end
   endtask

   // Cycle count FETCH-to-FETCH plus strobes seen, on dut1.
   task automatic measure(input int idx, input vec_t v);
      int   cyc, mcnt;
      logic psel, rfwe, memwe;
      cyc = 0; mcnt = 0; psel = 0; rfwe = 0; memwe = 0;
      opcode[1] = v.op;
      mm[1]     = v.mm;
      stat[1]   = v.stat;
      do begin
         if (st[1] == 3'd5) begin
            mem_ack[1] = (mcnt == v.w);
            mcnt++;
         end else begin
            mem_ack[1] = 1'b0;
         end
         #1;
         psel  |= pc_sel[1];
         rfwe  |= rf_we[1];
         memwe |= mem_we[1];
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end while (st[1] != 3'd2 && cyc < 40);
      check($sformatf("tbl%0d_len", idx),   16'(cyc),   16'(v.len));
      check($sformatf("tbl%0d_psel", idx),  16'(psel),  16'(v.psel));
      check($sformatf("tbl%0d_rfwe", idx),  16'(rfwe),  16'(v.rfwe));
      check($sformatf("tbl%0d_memwe", idx), 16'(memwe), 16'(v.memwe));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4'd0,  4'd0,  4'd0,  0, 3,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{4'd8,  4'd8,  4'd0,  0, 4,  1'b0, 1'b1, 1'b0};
      tbl[2]  = '{4'd8,  4'd3,  4'd5,  0, 4,  1'b0, 1'b1, 1'b0};
      tbl[3]  = '{4'd3,  4'd0,  4'd0,  0, 4,  1'b0, 1'b1, 1'b0};
      tbl[4]  = '{4'd1,  4'd0,  4'd0,  0, 5,  1'b0, 1'b1, 1'b0};
      tbl[5]  = '{4'd1,  4'd0,  4'd0,  3, 8,  1'b0, 1'b1, 1'b0};
      tbl[6]  = '{4'd2,  4'd0,  4'd0,  0, 4,  1'b0, 1'b0, 1'b1};
      tbl[7]  = '{4'd2,  4'd0,  4'd0,  2, 6,  1'b0, 1'b0, 1'b1};
      tbl[8]  = '{4'd4,  4'd2,  4'd2,  0, 3,  1'b1, 1'b0, 1'b0};
      tbl[9]  = '{4'd4,  4'd2,  4'd13, 0, 3,  1'b0, 1'b0, 1'b0};
      tbl[10] = '{4'd7,  4'd1,  4'd0,  0, 3,  1'b1, 1'b0, 1'b0};
      tbl[11] = '{4'd6,  4'd6,  4'd4,  0, 3,  1'b0, 1'b0, 1'b0};
      tbl[12] = '{4'd11, 4'd0,  4'd0,  0, 3,  1'b0, 1'b0, 1'b0};
      tbl[13] = '{4'd1,  4'd0,  4'd0,  7, 12, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{4'd5,  4'd15, 4'd1,  0, 3,  1'b1, 1'b0, 1'b0};

      for (int d = 0; d < 2; d++) begin
         rst_f[d] = 1'b0; opcode[d] = '0; mm[d] = '0; stat[d] = '0; mem_ack[d] = 1'b0;
         berr_m[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("dut0_in_reset", out_vec[0], 16'h0000);
      check("dut1_in_reset", out_vec[1], 16'h0000);

      // dut0: NOOP stream, memory ops, branches, ack on the timeout cycle.
      start_dut(0);
      build_instr(0, 4'd0, 4'd0, 4'd0, 0, 0);
      build_instr(0, 4'd0, 4'd0, 4'd0, 0, 0);
      build_instr(0, 4'd1, 4'd0, 4'd0, 2, 0);
      build_instr(0, 4'd2, 4'd0, 4'd0, 0, 0);
      build_instr(0, 4'd8, 4'd8, 4'd0, 0, 0);
      build_instr(0, 4'd4, 4'd2, 4'd2, 0, 0);
      build_instr(0, 4'd4, 4'd2, 4'd13, 0, 0);
      build_instr(0, 4'd7, 4'd1, 4'd0, 0, 0);
      build_instr(0, 4'd1, 4'd0, 4'd0, 3, 0);
      // LOD that never sees mem_ack: timeout into HALT with bus_err.
      build_instr(0, 4'd1, 4'd0, 4'd0, 1000, 3);
      run_q(0, 1000);
      do_reset(0);

      start_dut(0);
      build_instr(0, 4'd15, 4'd0, 4'd0, 0, 20);
      run_q(0, 1000);
      do_reset(0);

      // Reset while waiting in MEM.
      start_dut(0);
      build_instr(0, 4'd1, 4'd0, 4'd0, 3, 0);
      run_q(0, 6);
      do_reset(0);

      start_dut(0);
      random_instrs(0, 40);
      run_q(0, 1000);

      // dut1: skip mode, table then random.
      start_dut(1);
      run_q(1, 2);
      for (int i = 0; i < 15; i++)
         measure(i, tbl[i]);
      random_instrs(1, 40);
      build_instr(1, 4'd15, 4'd0, 4'd0, 0, 5);
      run_q(1, 1000);
      do_reset(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
